uncache_wbuf: RTL

UNCACHE_WBUF -- requirements
Module: uncache_wbuf

---
 rtl/uncache_pkg.sv | 15 +
 rtl/uncache_wfifo.sv | 54 +++++
 rtl/uncache_wbuf.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/uncache_pkg.sv
// Shared constants and read-FSM encoding for the uncached access unit.
package uncache_pkg;

  localparam int unsigned UNCACHE_ADDR_W     = 32;
  localparam int unsigned UNCACHE_DATA_W     = 32;
  localparam int unsigned UNCACHE_WBUF_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RD    = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/uncache_wfifo.sv
// Posted-store FIFO: DEPTH entries, pointers carry an extra wrap bit for full/empty.
module uncache_wfifo #(
  parameter int unsigned ENT_W = 68,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [ENT_W-1:0] wdata_i,
  output logic [ENT_W-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign rdata_o = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: an empty FIFO never exposes it.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uncache_wbuf.sv
// Uncached access unit: blocking loads, stores posted through a write FIFO.
// Define UNCACHE_WBUF_EN to build the write buffer; without it stores block until wr_done.
module uncache_wbuf
  import uncache_pkg::*;
#(
  parameter int unsigned ADDR_W     = UNCACHE_ADDR_W,
  parameter int unsigned DATA_W     = UNCACHE_DATA_W,
  parameter int unsigned WBUF_DEPTH = UNCACHE_WBUF_DEPTH
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                conf_en,
  input  logic [DATA_W/8-1:0] conf_wen,
  input  logic [ADDR_W-1:0]   conf_addr,
  input  logic [DATA_W-1:0]   conf_wdata,
  output logic [DATA_W-1:0]   conf_rdata,
  output logic                stallreq,
  output logic                rd_req,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic                reload,
  input  logic [DATA_W-1:0]   rd_data,
  output logic                wr_req,
  output logic [DATA_W/8-1:0] wr_wstrb,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  input  logic                wr_done
);

  localparam int unsigned STRB_W = DATA_W / 8;

  if ((DATA_W % 8) != 0 || WBUF_DEPTH < 2 || (WBUF_DEPTH & (WBUF_DEPTH - 1)) != 0) begin : g_param_chk
    $error("uncache_wbuf: DATA_W must be a multiple of 8 and WBUF_DEPTH a power of two >= 2");
  end

  rd_state_e         state_q, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              st_req, ld_req;
  logic              fifo_empty, push;
  logic              st_stall, st_done, ld_stall, rd_go;

  assign st_req = conf_en & (|conf_wen);
  assign ld_req = conf_en & ~(|conf_wen);

`ifdef UNCACHE_WBUF_EN
  localparam int unsigned ENT_W = ADDR_W + DATA_W + STRB_W;

  logic             fifo_full, pop;
  logic [ENT_W-1:0] head;

  assign push = st_req & ~fifo_full;
  assign pop  = wr_done & ~fifo_empty;

  uncache_wfifo #(
    .ENT_W (ENT_W),
    .DEPTH (WBUF_DEPTH)
  ) u_wfifo (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({conf_addr, conf_wdata, conf_wen}),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Head fields read as zero while empty, so reset clears them without touching storage.
  always_comb begin
    wr_req   = ~fifo_empty;
    wr_addr  = '0;
    wr_data  = '0;
    wr_wstrb = '0;
    if (!fifo_empty) begin
      wr_addr  = head[ENT_W-1 -: ADDR_W];
      wr_data  = head[STRB_W +: DATA_W];
      wr_wstrb = head[STRB_W-1:0];
    end
  end

  assign st_stall = st_req & fifo_full;
  assign st_done  = 1'b0;
`else
  assign fifo_empty = 1'b1;
  assign push       = 1'b0;

  // Blocking store: the request goes straight to the bus and IDLE doubles as the wait state.
  assign wr_req   = resetn & (state_q == ST_IDLE) & st_req;
  assign wr_addr  = wr_req ? conf_addr  : '0;
  assign wr_data  = wr_req ? conf_wdata : '0;
  assign wr_wstrb = wr_req ? conf_wen   : '0;

  assign st_stall = wr_req;
  assign st_done  = wr_req & wr_done;
`endif

  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    ld_stall = 1'b0;
    rd_go    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ld_req) begin
          ld_stall = 1'b1;
          state_d  = fifo_empty ? ST_RD : ST_DRAIN;
        end else if (st_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DRAIN: begin
        ld_stall = 1'b1;
        if (fifo_empty) state_d = ST_RD;
      end
      ST_RD: begin
        ld_stall = 1'b1;
        rd_go    = fifo_empty & ~push;
        if (rd_go && reload) begin
          rdata_d = rd_data;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // Request decode is combinational, so reset must mask the stall directly.
  assign stallreq   = resetn & (ld_stall | st_stall);
  assign rd_req     = rd_go;
  assign rd_addr    = rd_go ? conf_addr : '0;
  assign conf_rdata = rdata_q;

endmodule
